// File: rtl/stream_scalar_pkg.sv
// rtl/stream_scalar_pkg.sv - shared types and helpers for the scalar broadcast arbiter
package stream_scalar_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_REPLAY  = 2'd2
  } state_t;

  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/axi_stream_if.sv
// rtl/axi_stream_if.sv - scalar stream bundle used for the broadcast output
interface axi_stream_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] tdata;
  logic              tvalid;
  logic              tready;
  logic              tlast;

  modport axi_out (output tdata, output tvalid, output tlast, input tready);
  modport axi_in  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/stream_scalar_arb_rr_pick.sv
// rtl/stream_scalar_arb_rr_pick.sv - combinational round-robin picker
// Search begins one past the previous winner and wraps modulo NREQ.
module rr_pick #(
  parameter int NREQ = 4,
  parameter int ID_W = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [ID_W-1:0] last,
  output logic [ID_W-1:0] gnt_idx,
  output logic            any
);

  int w_idx;

  always_comb begin
    gnt_idx = '0;
    any     = 1'b0;
    w_idx   = 0;
    for (int k = 1; k <= NREQ; k++) begin
      w_idx = (int'(last) + k) % NREQ;
      if (!any && req[w_idx[ID_W-1:0]]) begin
        any     = 1'b1;
        gnt_idx = w_idx[ID_W-1:0];
      end
    end
  end

endmodule

// File: rtl/stream_scalar_arb.sv
// rtl/stream_scalar_arb.sv - round-robin scalar capture and DIM1xDIM2 broadcast replay
// Handshake-facing outputs are decoded from registered state only.
module stream_scalar_arb
  import stream_scalar_pkg::*;
#(
  parameter int D_W          = 8,
  parameter int MATRIXSIZE_W = 24,
  parameter int NREQ         = 4,
  parameter int ID_W         = clog2_min1(NREQ)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NREQ*D_W-1:0]          in_tdata,
  input  logic [NREQ-1:0]              in_tvalid,
  input  logic [NREQ-1:0]              in_tlast,
  output logic [NREQ-1:0]              in_tready,
  input  logic [NREQ*MATRIXSIZE_W-1:0] dim1,
  input  logic [NREQ*MATRIXSIZE_W-1:0] dim2,
  axi_stream_if.axi_out                out_sca,
  output logic [ID_W-1:0]              out_id,
  output logic                         busy
);

  localparam logic [MATRIXSIZE_W-1:0] ONE = MATRIXSIZE_W'(1);

  state_t                  r_state;
  logic [ID_W-1:0]         r_grant;
  logic [ID_W-1:0]         r_last_grant;
  logic [MATRIXSIZE_W-1:0] r_d1;
  logic [MATRIXSIZE_W-1:0] r_d2;
  logic [MATRIXSIZE_W-1:0] r_row;
  logic [MATRIXSIZE_W-1:0] r_col;
  logic [D_W-1:0]          r_scalar;

  logic [ID_W-1:0]         w_pick_idx;
  logic                    w_req_any;
  logic [MATRIXSIZE_W-1:0] w_dim1_sel;
  logic [MATRIXSIZE_W-1:0] w_dim2_sel;
  logic [D_W-1:0]          w_in_data;
  logic                    w_in_last;
  logic                    w_hs_in;
  logic                    w_replay;
  logic                    w_tlast;

  rr_pick #(
    .NREQ (NREQ),
    .ID_W (ID_W)
  ) u_pick (
    .req     (in_tvalid),
    .last    (r_last_grant),
    .gnt_idx (w_pick_idx),
    .any     (w_req_any)
  );

  assign w_dim1_sel = dim1[w_pick_idx*MATRIXSIZE_W +: MATRIXSIZE_W];
  assign w_dim2_sel = dim2[w_pick_idx*MATRIXSIZE_W +: MATRIXSIZE_W];
  assign w_in_data  = in_tdata[r_grant*D_W +: D_W];
  assign w_in_last  = in_tlast[r_grant];
  assign w_hs_in    = (r_state == ST_CAPTURE) && in_tvalid[r_grant];
  assign w_replay   = (r_state == ST_REPLAY);
  assign w_tlast    = (r_col == r_d2 - ONE) && (r_row == r_d1 - ONE);

  assign in_tready      = (r_state == ST_CAPTURE) ? (NREQ'(1) << r_grant) : '0;
  assign out_sca.tvalid = w_replay;
  assign out_sca.tlast  = w_replay && w_tlast;
  assign out_sca.tdata  = w_replay ? r_scalar : '0;
  assign out_id         = r_grant;
  assign busy           = (r_state != ST_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_grant      <= '0;
      r_last_grant <= ID_W'(NREQ - 1);
      r_d1         <= '0;
      r_d2         <= '0;
      r_row        <= '0;
      r_col        <= '0;
      r_scalar     <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_req_any) begin
            r_grant <= w_pick_idx;
            // Zero-sized dimensions still produce one beat along that axis.
            r_d1    <= (w_dim1_sel == '0) ? ONE : w_dim1_sel;
            r_d2    <= (w_dim2_sel == '0) ? ONE : w_dim2_sel;
            r_state <= ST_CAPTURE;
          end
        end
        ST_CAPTURE: begin
          if (w_hs_in) begin
            r_scalar <= w_in_data;
            if (w_in_last) begin
              r_state <= ST_REPLAY;
            end
          end
        end
        ST_REPLAY: begin
          if (out_sca.tready) begin
            if (w_tlast) begin
              r_row        <= '0;
              r_col        <= '0;
              r_last_grant <= r_grant;
              r_state      <= ST_IDLE;
            end else if (r_col == r_d2 - ONE) begin
              r_col <= '0;
              r_row <= r_row + ONE;
            end else begin
              r_col <= r_col + ONE;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
